// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller:
// ALU control codes, opcodes, funct codes, FSM states.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;

  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_SUB = 3'b110;
  localparam logic [2:0] FN_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_e;

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x16 register file: one write port, read ports rs/rt/dbg.
// Macro ALU_ISSUE_R0_ZERO_EN: r0 hardwired to zero.
module alu_issue_regfile
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       rs_addr,
  input  logic [2:0]       rt_addr,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem [NREGS];
  logic             we_eff;

`ifdef ALU_ISSUE_R0_ZERO_EN
  assign we_eff   = we && (waddr != 3'd0);
  assign rs_data  = (rs_addr == 3'd0) ? '0 : mem[rs_addr];
  assign rt_data  = (rt_addr == 3'd0) ? '0 : mem[rt_addr];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : mem[dbg_addr];
`else
  assign we_eff   = we;
  assign rs_data  = mem[rs_addr];
  assign rt_data  = mem[rt_addr];
  assign dbg_data = mem[dbg_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we_eff) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes an instruction, drives the ALU, writes back.
// Ports: instr handshake, ALU source1/source2/ALU_CTRL/result, done/err/wb_data, dbg read.
// Macro ALU_ISSUE_R0_ZERO_EN: r0 reads zero, writes to r0 dropped.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [WIDTH-1:0] source1,
  output logic [WIDTH-1:0] source2,
  output logic [3:0]       ALU_CTRL,
  input  logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] wb_data,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           state, state_nx;
  logic [15:0]      instr_q;
  logic             err_q;
  logic [3:0]       op;
  logic [2:0]       rd, rs, rt, fn;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rs_data, rt_data;
  logic             legal;
  logic             is_addi;
  logic [3:0]       ctrl;

  assign op  = instr_q[15:12];
  assign rd  = instr_q[11:9];
  assign rs  = instr_q[8:6];
  assign rt  = instr_q[5:3];
  assign fn  = instr_q[2:0];
  assign imm = {{(WIDTH-6){instr_q[5]}}, instr_q[5:0]};

  always_comb begin
    legal   = 1'b0;
    is_addi = 1'b0;
    ctrl    = CTRL_AND;
    unique case (1'b1)
      op == OP_RTYPE && fn == FN_AND: begin
        legal = 1'b1; ctrl = CTRL_AND;
      end
      op == OP_RTYPE && fn == FN_OR: begin
        legal = 1'b1; ctrl = CTRL_OR;
      end
      op == OP_RTYPE && fn == FN_ADD: begin
        legal = 1'b1; ctrl = CTRL_ADD;
      end
      op == OP_RTYPE && fn == FN_SUB: begin
        legal = 1'b1; ctrl = CTRL_SUB;
      end
      op == OP_RTYPE && fn == FN_SLT: begin
        legal = 1'b1; ctrl = CTRL_SLT;
      end
      op == OP_ADDI: begin
        legal = 1'b1; is_addi = 1'b1; ctrl = CTRL_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (instr_valid) state_nx = S_DECODE;
      S_DECODE: state_nx = legal ? S_EXEC : S_WB;
      S_EXEC:   state_nx = S_WB;
      S_WB:     state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign instr_ready = (state == S_IDLE);
  assign done        = (state == S_WB);
  assign err         = (state == S_WB) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      err_q    <= 1'b0;
      source1  <= '0;
      source2  <= '0;
      ALU_CTRL <= CTRL_AND;
      wb_data  <= '0;
    end else begin
      if (state == S_IDLE && instr_valid) instr_q <= instr;
      if (state == S_DECODE) begin
        err_q <= !legal;
        // Illegal instructions leave the ALU inputs untouched.
        if (legal) begin
          source1  <= rs_data;
          source2  <= is_addi ? imm : rt_data;
          ALU_CTRL <= ctrl;
        end else begin
          wb_data <= '0;
        end
      end
      if (state == S_EXEC) wb_data <= result;
    end
  end

  alu_issue_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state == S_WB && !err_q),
    .waddr    (rd),
    .wdata    (wb_data),
    .rs_addr  (rs),
    .rt_addr  (rt),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, scoreboard of retirements,
// directed vectors, reset and illegal-instruction cases.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [15:0] source1, source2;
  logic [3:0]  ALU_CTRL;
  logic [15:0] result;
  logic        done, err;
  logic [15:0] wb_data;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  typedef struct {
    logic        err;
    logic [15:0] wb;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   gaps[$];
  int   cyc = 0;
  int   acc_last = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .source1     (source1),
    .source2     (source2),
    .ALU_CTRL    (ALU_CTRL),
    .result      (result),
    .done        (done),
    .err         (err),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural 16-bit ALU the controller drives.
  always_comb begin
    result = '0;
    case (ALU_CTRL)
      4'b0000: result = source1 & source2;
      4'b0001: result = source1 | source2;
      4'b0010: result = source1 + source2;
      4'b0110: result = source1 - source2;
      4'b0111: result = {15'd0, source1 < source2};
      default: result = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rtype(input logic [2:0] rd,
      input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] fn);
    return {4'b0000, rd, rs, rt, fn};
  endfunction

  function automatic logic [15:0] addi(input logic [2:0] rd,
      input logic [2:0] rs, input logic [5:0] imm);
    return {4'b0001, rd, rs, imm};
  endfunction

  // Accept edge numbering and spacing.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && instr_valid && instr_ready) begin
      acc_q.push_back(cyc);
      gaps.push_back(cyc - acc_last);
      acc_last = cyc;
    end
  end

  // Monitor: pops the scoreboard on every retirement.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      acc_q.delete();
    end else if (done) begin
      if (sb.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_done", {16'd0, wb_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        int   a;
        e = sb.pop_front();
        a = acc_q.pop_front();
        chk("retire_err", {31'd0, err}, {31'd0, e.err});
        chk("retire_wb", {16'd0, wb_data}, {16'd0, e.wb});
        chk("retire_lat", cyc + 1 - a, e.lat);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !instr_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("drain_timeout", n, 0);
  endtask

  task automatic issue(input logic [15:0] i, input logic [15:0] w,
                       input logic e);
    exp_t x;
    int   n = 0;
    x.err = e;
    x.wb  = w;
    x.lat = e ? 2 : 3;
    sb.push_back(x);
    @(negedge clk);
    instr = i;
    instr_valid = 1'b1;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    drain();
  endtask

  task automatic dbg(input string nm, input logic [2:0] a,
                     input logic [15:0] exp);
    dbg_addr = a;
    #1 chk(nm, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  logic [15:0] bb [3];

  initial begin
    #3;
    chk("rst_ready", {31'd0, instr_ready}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_wb", {16'd0, wb_data}, 0);
    chk("rst_s1", {16'd0, source1}, 0);
    chk("rst_s2", {16'd0, source2}, 0);
    chk("rst_ctrl", {28'd0, ALU_CTRL}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of an ADD.
    issue(addi(3'd1, 3'd0, 6'd5), 16'h0005, 1'b0);
    dbg("pre_rst_r1", 3'd1, 16'h0005);
    @(negedge clk);
    instr = rtype(3'd3, 3'd1, 3'd1, 3'b010);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #2 chk("exec_s1", {16'd0, source1}, 32'h0005);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, instr_ready}, 1);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_err", {31'd0, err}, 0);
    chk("mid_rst_wb", {16'd0, wb_data}, 0);
    chk("mid_rst_s1", {16'd0, source1}, 0);
    chk("mid_rst_s2", {16'd0, source2}, 0);
    chk("mid_rst_ctrl", {28'd0, ALU_CTRL}, 0);
    for (int r = 0; r < 8; r++) dbg("mid_rst_reg", r[2:0], 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    dbg("post_rst_r3", 3'd3, 16'h0000);

    // Arithmetic vectors.
    issue(addi(3'd1, 3'd0, 6'd5), 16'h0005, 1'b0);
    issue(addi(3'd2, 3'd0, 6'b111101), 16'hFFFD, 1'b0);
    dbg("r1", 3'd1, 16'h0005);
    dbg("r2", 3'd2, 16'hFFFD);
    issue(rtype(3'd3, 3'd1, 3'd2, 3'b010), 16'h0002, 1'b0);
    dbg("r3_add", 3'd3, 16'h0002);
    issue(rtype(3'd4, 3'd1, 3'd2, 3'b110), 16'h0008, 1'b0);
    dbg("r4_sub", 3'd4, 16'h0008);
    issue(rtype(3'd5, 3'd1, 3'd2, 3'b000), 16'h0005, 1'b0);
    issue(rtype(3'd6, 3'd1, 3'd2, 3'b001), 16'hFFFD, 1'b0);
    dbg("r6_or", 3'd6, 16'hFFFD);
    issue(rtype(3'd5, 3'd1, 3'd2, 3'b111), 16'h0001, 1'b0);
    dbg("r5_slt1", 3'd5, 16'h0001);
    issue(rtype(3'd5, 3'd2, 3'd1, 3'b111), 16'h0000, 1'b0);
    dbg("r5_slt0", 3'd5, 16'h0000);
    issue(addi(3'd7, 3'd0, 6'b111111), 16'hFFFF, 1'b0);
    issue(addi(3'd6, 3'd0, 6'd1), 16'h0001, 1'b0);
    issue(rtype(3'd7, 3'd7, 3'd6, 3'b010), 16'h0000, 1'b0);
    dbg("r7_wrap", 3'd7, 16'h0000);

    // Illegal instructions keep ALU inputs and registers.
    issue(rtype(3'd1, 3'd1, 3'd2, 3'b011), 16'h0000, 1'b1);
    issue(16'hF2D1, 16'h0000, 1'b1);
    dbg("ill_r1", 3'd1, 16'h0005);
    chk("ill_ctrl", {28'd0, ALU_CTRL}, 32'h2);
    chk("ill_s1", {16'd0, source1}, 32'hFFFF);
    chk("ill_s2", {16'd0, source2}, 32'h0001);

    // Valid held high across three instructions.
    bb[0] = addi(3'd1, 3'd0, 6'd1);
    bb[1] = addi(3'd2, 3'd0, 6'd2);
    bb[2] = addi(3'd3, 3'd0, 6'd3);
    for (int k = 0; k < 3; k++) begin
      exp_t x;
      x.err = 1'b0;
      x.wb  = 16'(k + 1);
      x.lat = 3;
      sb.push_back(x);
    end
    @(negedge clk);
    gaps.delete();
    instr = bb[0];
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (!instr_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
      if (k < 2) instr = bb[k+1];
      else instr_valid = 1'b0;
    end
    drain();
    chk("b2b_count", gaps.size(), 3);
    if (gaps.size() == 3) begin
      chk("b2b_gap1", gaps[1], 4);
      chk("b2b_gap2", gaps[2], 4);
    end
    dbg("b2b_r3", 3'd3, 16'h0003);

    // Writes to r0.
    issue(addi(3'd0, 3'd0, 6'd7), 16'h0007, 1'b0);
`ifdef ALU_ISSUE_R0_ZERO_EN
    dbg("r0", 3'd0, 16'h0000);
`else
    dbg("r0", 3'd0, 16'h0007);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue controller that drives the 16-bit combinational ALU. It accepts 16-bit instructions over a valid/ready handshake and decodes opcode/funct into the 4-bit ALU control code. It reads operands from an internal 8×16 register file, presents them to the ALU, captures the ALU result, and writes it back. It sits between the instruction source and the ALU, and produces every `source1`/`source2`/`ALU_CTRL` value the ALU consumes.

## Interface
- `NREGS`, 8: register-file depth; fixed at 8 (3-bit indices).
- `WIDTH`, 16: datapath width; must match the ALU.
- `clk` input 1: single clock, all state on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr_valid` input 1: instruction offered.
- `instr` input 16: `[15:12]` opcode, `[11:9]` rd, `[8:6]` rs, `[5:3]` rt, `[2:0]` funct; for ADDI, `[5:0]` is imm6.
- `instr_ready` output 1: high only in IDLE.
- `source1` output 16: ALU operand A (registered).
- `source2` output 16: ALU operand B (registered).
- `ALU_CTRL` output 4: ALU operation code (registered).
- `result` input 16: ALU combinational result.
- `done` output 1: one-cycle pulse at retirement.
- `err` output 1: valid with `done`; 1 means illegal instruction.
- `wb_data` output 16: value written back, valid with `done`.
- `dbg_addr` input 3: debug read index.
- `dbg_data` output 16: combinational read of `reg[dbg_addr]`.

## Operation
- Opcode 0000 (R-type) decodes funct as follows:
  - 000 AND → 0000
  - 001 OR → 0001
  - 010 ADD → 0010
  - 110 SUB → 0110
  - 111 SLT → 0111
  - funct 011/100/101 are illegal.
- Opcode 0001 (ADDI): ALU_CTRL=0010, source2 = imm6 sign-extended to 16 bits.
- All other opcodes are illegal.
- Operand selection: source1=reg[rs]. source2=reg[rt] for R-type, the sign-extended immediate for ADDI.
- Arithmetic: 16-bit wrap-around; the ALU is trusted and no overflow is detected. SLT is unsigned: result is 1 or 0.
- States:
  - IDLE: instr_ready=1. On valid&&ready, latch instr → DECODE.
  - DECODE: register operands and ALU_CTRL. Legal → EXEC; illegal → WB with err flagged.
  - EXEC: hold ALU inputs; capture `result` into wb_data → WB.
  - WB: write wb_data to reg[rd] if legal; pulse done (err as decoded) → IDLE.
- Illegal instruction: ALU outputs keep their previous values, wb_data=0, no register write, done=1 and err=1.
- rd==rs or rd==rt: operands were read in DECODE, so they use pre-write values.
- dbg_data reflects a register write in the cycle after WB.

## Timing
- Latency: accept at edge N; done high during cycle N+3 for legal instructions, N+2 for illegal ones.
- Throughput: one instruction per 4 cycles (legal), per 3 cycles (illegal). No overlap.
- instr_valid while not ready: ignored. The source must hold instr until accepted.
- Reset (asynchronous, any state, including mid-instruction):
  - state=IDLE, so instr_ready=1 once reset deasserts.
  - source1=0, source2=0, ALU_CTRL=0000.
  - done=0, err=0, wb_data=0, all registers 0.
  - An in-flight instruction is discarded with no writeback.
- done and err deassert in the cycle after WB.

## Configuration
- `ALU_ISSUE_R0_ZERO_EN`
  - Defined: reg[0] always reads 0 (including dbg_data); writes to rd=0 are dropped, but done/wb_data still report the computed value.
  - Undefined: reg[0] is an ordinary register.

## Structure
- Shared package `alu_pkg`:
  - ALU_CTRL constants (AND/OR/ADD/SUB/SLT).
  - opcode constants (RTYPE, ADDI).
  - funct constants.
  - the state enum.
  - WIDTH.
- One sub-module `alu_issue_regfile`: 8×16, one write port, three combinational read ports (rs, rt, dbg). Reset clears all registers.
- The FSM and decode stay in the top-level module.

## Test plan
- Reset mid-EXEC of an ADD → all outputs at their reset values, instr_ready=1, register file all 0.
- ADDI r1,r0,+5 then ADDI r2,r0,-3 → wb_data=0x0005, then 0xFFFD; dbg r2=0xFFFD; each done 3 cycles after accept.
- With r1=5, r2=0xFFFD:
  - ADD r3,r1,r2 → 0x0002.
  - SUB r4,r1,r2 → 0x0008.
  - AND → 0x0005.
  - OR → 0xFFFD.
- SLT r5,r1,r2 → 1; SLT r5,r2,r1 → 0; ADD 0xFFFF+0x0001 → 0x0000 (wrap).
- Illegal instructions (funct 011; opcode 1111) → done=1, err=1, 2 cycles after accept; no register changed.
- Back-to-back valid held high → accepts spaced 4 cycles apart. ADDI r0,r0,7 with the macro defined → r0 still 0 and wb_data=7; without the macro → r0=7.
